// File: rtl/pe_datapath_gen_if.sv
// pe_datapath_gen_if: control, stream and partial-sum signals of one systolic PE cell
interface pe_datapath_gen_if #(
   parameter int D_W   = 8,
   parameter int ACC_W = 20
);
   logic             mode, load_en, swap, drain;
   logic [D_W-1:0]   in_act, in_weight, out_act, out_weight;
   logic             in_act_vld, in_weight_vld, out_act_vld, out_weight_vld;
   logic [ACC_W-1:0] in_sum, out_sum;
   logic             in_sum_vld, out_sum_vld, out_bank;
   modport master (
      output mode, load_en, swap, drain, in_act, in_act_vld, in_weight, in_weight_vld, in_sum, in_sum_vld,
      input  out_act, out_act_vld, out_weight, out_weight_vld, out_sum, out_sum_vld, out_bank
   );
   modport slave (
      input  mode, load_en, swap, drain, in_act, in_act_vld, in_weight, in_weight_vld, in_sum, in_sum_vld,
      output out_act, out_act_vld, out_weight, out_weight_vld, out_sum, out_sum_vld, out_bank
   );
endinterface

// File: rtl/pe_datapath_gen.sv
// pe_datapath_gen: dual-mode (stationary / output-stationary) systolic PE, optional fault injection via PE_FAULT_INJ_EN
module pe_datapath_gen #(
   parameter int D_W    = 8,
   parameter int ACC_W  = 20,
   parameter int SIGNED = 0,
   parameter int SAT    = 0,
   parameter int ROW    = 0,
   parameter int COL    = 0
) (
   input  logic             clk,
   input  logic             rst,
`ifdef PE_FAULT_INJ_EN
   input  logic             fi_en,
   input  logic [7:0]       fi_row,
   input  logic [7:0]       fi_col,
   input  logic [1:0]       fi_type,
   input  logic [ACC_W-1:0] fi_mask,
`endif
   pe_datapath_gen_if.slave io
);
   localparam bit SGN = SIGNED != 0;
   localparam bit SATB = SAT != 0;
   localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {ACC, SHIFT} state_t;
   state_t           state_q, state_d;
   logic             mode_q, bank_sel_q, bank_sel_d;
   logic [D_W-1:0]   bank_q [2];
   logic [D_W-1:0]   bank_d [2];
   logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, sum_fi;
   logic             sum_vld_q, sum_vld_d;
   logic [D_W-1:0]   act_q, wt_q, op_b;
   logic             act_vld_q, wt_vld_q;
   logic [2*D_W-1:0] prod;
   logic [ACC_W-1:0] prod_x, add_a, add_r;
   logic [ACC_W:0]   sum_w;
   logic             mac, mode_chg, ovf;

   // multiply then one shared ACC_W+1 adder: in_sum in stationary mode, acc in OS mode
   always_comb begin
      op_b   = io.mode ? io.in_weight : bank_q[bank_sel_q];
      prod   = {{D_W{SGN & io.in_act[D_W-1]}}, io.in_act} * {{D_W{SGN & op_b[D_W-1]}}, op_b};
      prod_x = {ACC_W{SGN & prod[2*D_W-1]}};
      prod_x[2*D_W-1:0] = prod;
      add_a  = io.mode ? acc_q : io.in_sum;
      sum_w  = {SGN & add_a[ACC_W-1], add_a} + {SGN & prod_x[ACC_W-1], prod_x};
      ovf    = SGN ? sum_w[ACC_W] ^ sum_w[ACC_W-1] : sum_w[ACC_W];
      add_r  = !(SATB && ovf) ? sum_w[ACC_W-1:0] : !SGN ? '1 : sum_w[ACC_W] ? S_MIN : S_MAX;
   end

   // shadow-bank write and bank swap; a same-cycle write lands in the bank about to go active
   always_comb begin
      bank_d = bank_q;
      if (io.load_en && io.in_weight_vld) bank_d[~bank_sel_q] = io.in_weight;
      bank_sel_d = bank_sel_q ^ (io.swap & ~io.mode);
   end

   // sum path and OS accumulate/drain state machine; a mode change flushes the cycle
   always_comb begin
      mac       = io.in_act_vld & io.in_weight_vld;
      mode_chg  = io.mode != mode_q;
      state_d   = state_q;
      acc_d     = acc_q;
      sum_d     = io.in_sum;
      sum_vld_d = io.in_sum_vld;
      if (mode_chg) begin
         state_d   = ACC;
         acc_d     = '0;
         sum_d     = '0;
         sum_vld_d = 1'b0;
      end else if (!io.mode) begin
         sum_d = io.in_act_vld ? add_r : io.in_sum;
      end else if (io.drain) begin
         state_d   = SHIFT;
         acc_d     = mac ? prod_x : '0;
         sum_d     = acc_q;
         sum_vld_d = 1'b1;
      end else begin
         acc_d   = mac ? add_r : acc_q;
         state_d = io.in_sum_vld ? state_q : ACC;
      end
   end

`ifdef PE_FAULT_INJ_EN
   // corrupt the registered sum value only when this cell is addressed
   always_comb begin
      sum_fi = sum_d;
      if (fi_en && fi_row == 8'(ROW) && fi_col == 8'(COL))
         sum_fi = fi_type == 2'd0 ? sum_d & ~fi_mask : fi_type == 2'd1 ? sum_d | fi_mask :
                  fi_type == 2'd2 ? sum_d ^ fi_mask : sum_d;
   end
`else
   logic [15:0] unused_id;
   assign unused_id = {8'(ROW), 8'(COL)};
   assign sum_fi = sum_d;
`endif

   // state registers and 1-cycle pass-through of both operand streams
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACC;
         mode_q     <= 1'b0;
         bank_sel_q <= 1'b0;
         bank_q[0]  <= '0;
         bank_q[1]  <= '0;
         acc_q      <= '0;
         sum_q      <= '0;
         sum_vld_q  <= 1'b0;
         act_q      <= '0;
         act_vld_q  <= 1'b0;
         wt_q       <= '0;
         wt_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= io.mode;
         bank_sel_q <= bank_sel_d;
         bank_q     <= bank_d;
         acc_q      <= acc_d;
         sum_q      <= sum_fi;
         sum_vld_q  <= sum_vld_d;
         act_q      <= io.in_act;
         act_vld_q  <= io.in_act_vld;
         wt_q       <= io.in_weight;
         wt_vld_q   <= io.in_weight_vld;
      end
   end

   assign io.out_act        = act_q;
   assign io.out_act_vld    = act_vld_q;
   assign io.out_weight     = wt_q;
   assign io.out_weight_vld = wt_vld_q;
   assign io.out_sum        = sum_q;
   assign io.out_sum_vld    = sum_vld_q;
   assign io.out_bank       = bank_sel_q;
endmodule

// File: tb/tb_pe_datapath_gen.sv
// tb_pe_datapath_gen: directed checks of pe_datapath_gen (single cell, 3-row column, arithmetic corners)
module tb_pe_datapath_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic       col_mode = 1'b0, col_drain = 1'b0, col_vld = 1'b0;
   logic [7:0] col_act0 = '0, col_act1 = '0, col_act2 = '0;
`ifdef PE_FAULT_INJ_EN
   logic        fi_en = 1'b0;
   logic [7:0]  fi_row = '0, fi_col = '0;
   logic [1:0]  fi_type = '0;
   logic [19:0] fi_mask = '0;
`endif

   pe_datapath_gen_if #(.D_W(8), .ACC_W(20)) m ();
   pe_datapath_gen_if #(.D_W(8), .ACC_W(20)) c0 ();
   pe_datapath_gen_if #(.D_W(8), .ACC_W(20)) c1 ();
   pe_datapath_gen_if #(.D_W(8), .ACC_W(20)) c2 ();
   pe_datapath_gen_if #(.D_W(8), .ACC_W(20)) s ();
   pe_datapath_gen_if #(.D_W(8), .ACC_W(16)) t ();
   pe_datapath_gen_if #(.D_W(8), .ACC_W(16)) w ();

   pe_datapath_gen #(.D_W(8), .ACC_W(20), .ROW(0), .COL(0)) u_m (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask),
`endif
      .io(m));
   pe_datapath_gen #(.D_W(8), .ACC_W(20), .ROW(0), .COL(1)) u_c0 (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask),
`endif
      .io(c0));
   pe_datapath_gen #(.D_W(8), .ACC_W(20), .ROW(1), .COL(1)) u_c1 (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask),
`endif
      .io(c1));
   pe_datapath_gen #(.D_W(8), .ACC_W(20), .ROW(2), .COL(1)) u_c2 (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask),
`endif
      .io(c2));
   pe_datapath_gen #(.D_W(8), .ACC_W(20), .SIGNED(1), .COL(2)) u_s (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask),
`endif
      .io(s));
   pe_datapath_gen #(.D_W(8), .ACC_W(16), .SAT(1), .COL(3)) u_t (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask[15:0]),
`endif
      .io(t));
   pe_datapath_gen #(.D_W(8), .ACC_W(16), .SAT(0), .COL(4)) u_w (.clk(clk), .rst(rst),
`ifdef PE_FAULT_INJ_EN
      .fi_en(fi_en), .fi_row(fi_row), .fi_col(fi_col), .fi_type(fi_type), .fi_mask(fi_mask[15:0]),
`endif
      .io(w));

   assign c0.mode = col_mode;  assign c1.mode = col_mode;  assign c2.mode = col_mode;
   assign c0.drain = col_drain; assign c1.drain = col_drain; assign c2.drain = col_drain;
   assign c0.load_en = 1'b0;   assign c1.load_en = 1'b0;   assign c2.load_en = 1'b0;
   assign c0.swap = 1'b0;      assign c1.swap = 1'b0;      assign c2.swap = 1'b0;
   assign c0.in_act = col_act0; assign c1.in_act = col_act1; assign c2.in_act = col_act2;
   assign c0.in_act_vld = col_vld; assign c1.in_act_vld = col_vld; assign c2.in_act_vld = col_vld;
   assign c0.in_weight = 8'd1; assign c1.in_weight = 8'd1; assign c2.in_weight = 8'd1;
   assign c0.in_weight_vld = col_vld; assign c1.in_weight_vld = col_vld; assign c2.in_weight_vld = col_vld;
   assign c0.in_sum = '0;      assign c0.in_sum_vld = 1'b0;
   assign c1.in_sum = c0.out_sum; assign c1.in_sum_vld = c0.out_sum_vld;
   assign c2.in_sum = c1.out_sum; assign c2.in_sum_vld = c1.out_sum_vld;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      m.mode = 0; m.load_en = 0; m.swap = 0; m.drain = 0; m.in_weight = 0; m.in_weight_vld = 0;
      m.in_act = 8'h55; m.in_act_vld = 1; m.in_sum = 20'd5; m.in_sum_vld = 1;
      s.mode = 0; s.load_en = 0; s.swap = 0; s.drain = 0; s.in_act = 0; s.in_act_vld = 0;
      s.in_weight = 0; s.in_weight_vld = 0; s.in_sum = 0; s.in_sum_vld = 0;
      t.mode = 0; t.load_en = 0; t.swap = 0; t.drain = 0; t.in_act = 0; t.in_act_vld = 0;
      t.in_weight = 0; t.in_weight_vld = 0; t.in_sum = 0; t.in_sum_vld = 0;
      w.mode = 0; w.load_en = 0; w.swap = 0; w.drain = 0; w.in_act = 0; w.in_act_vld = 0;
      w.in_weight = 0; w.in_weight_vld = 0; w.in_sum = 0; w.in_sum_vld = 0;
      rst = 1;
      tick; tick;
      chk("rst_sum", m.out_sum, 0);
      chk("rst_sum_vld", m.out_sum_vld, 0);
      chk("rst_bank", m.out_bank, 0);
      chk("rst_act_vld", m.out_act_vld, 0);
      chk("rst_col_vld", c2.out_sum_vld, 0);
      rst = 0; m.in_act = 0; m.in_act_vld = 0; m.in_sum = 0; m.in_sum_vld = 0;
      // stationary load + swap
      m.load_en = 1; m.in_weight = 3; m.in_weight_vld = 1; tick;
      chk("t1_out_weight", m.out_weight, 3);
      chk("t1_out_weight_vld", m.out_weight_vld, 1);
      chk("t1_bank_pre_swap", m.out_bank, 0);
      m.load_en = 0; m.in_weight_vld = 0; m.swap = 1; tick;
      chk("t1_bank_post_swap", m.out_bank, 1);
      m.swap = 0; m.in_act = 4; m.in_act_vld = 1; m.in_sum = 10; m.in_sum_vld = 1; tick;
      chk("t1_sum", m.out_sum, 22);
      chk("t1_sum_vld", m.out_sum_vld, 1);
      chk("t1_out_act", m.out_act, 4);
      // overlapped reload
      m.in_act = 2; m.in_sum = 0; m.load_en = 1; m.in_weight = 7; m.in_weight_vld = 1; tick;
      chk("t2_mac0", m.out_sum, 6);
      m.load_en = 0; m.in_weight_vld = 0; tick;
      chk("t2_mac1", m.out_sum, 6);
      m.swap = 1; m.in_act_vld = 0; m.in_sum = 5; tick;
      chk("t2_bubble", m.out_sum, 5);
      chk("t2_bank", m.out_bank, 0);
      m.swap = 0; m.in_act_vld = 1; m.in_sum = 0; tick;
      chk("t2_new_stat", m.out_sum, 14);
      m.load_en = 1; m.swap = 1; m.in_weight = 9; m.in_weight_vld = 1; tick;
      chk("t2_ldswap_same", m.out_sum, 14);
      chk("t2_ldswap_bank", m.out_bank, 1);
      m.load_en = 0; m.swap = 0; m.in_weight_vld = 0; tick;
      chk("t2_ldswap_next", m.out_sum, 18);
      // OS accumulate + drain
      m.mode = 1; m.swap = 1; m.in_act_vld = 0; m.in_sum = 7; m.in_sum_vld = 1; tick;
      chk("t3_modechg_vld", m.out_sum_vld, 0);
      chk("t3_swap_ignored", m.out_bank, 1);
      m.swap = 0; m.in_sum = 0; m.in_sum_vld = 0;
      m.in_act = 5; m.in_weight = 6; m.in_act_vld = 1; m.in_weight_vld = 1;
      repeat (4) tick;
      chk("t3_acc_vld", m.out_sum_vld, 0);
      m.drain = 1; m.in_act = 1; m.in_weight = 1; tick;
      chk("t3_drain", m.out_sum, 120);
      chk("t3_drain_vld", m.out_sum_vld, 1);
      m.drain = 0; m.in_act_vld = 0; m.in_weight_vld = 0; tick;
      chk("t3_shift_vld", m.out_sum_vld, 0);
      m.drain = 1; tick;
      chk("t3_acc_after_drain", m.out_sum, 1);
      chk("t3_acc_after_drain_vld", m.out_sum_vld, 1);
      m.drain = 0; tick;
      // mode switch mid-accumulation
      m.in_act = 5; m.in_weight = 6; m.in_act_vld = 1; m.in_weight_vld = 1;
      repeat (2) tick;
      m.mode = 0; m.in_act_vld = 0; m.in_weight_vld = 0; m.in_sum = 33; m.in_sum_vld = 1; tick;
      chk("t6_modechg_vld", m.out_sum_vld, 0);
      tick;
      chk("t6_mode0_fwd", m.out_sum, 33);
      m.mode = 1; m.in_sum_vld = 0; tick;
      m.drain = 1; tick;
      chk("t6_acc_cleared", m.out_sum, 0);
      chk("t6_acc_cleared_vld", m.out_sum_vld, 1);
      m.drain = 0; m.in_act_vld = 1; m.in_weight_vld = 1; tick;
      // reset mid-drain
      m.in_act_vld = 0; m.in_weight_vld = 0; m.drain = 1; rst = 1; tick;
      chk("t6_rst_vld", m.out_sum_vld, 0);
      chk("t6_rst_sum", m.out_sum, 0);
      chk("t6_rst_bank", m.out_bank, 0);
      rst = 0; m.drain = 0; m.mode = 0; tick;
      m.mode = 1; tick;
      m.drain = 1; tick;
      chk("t6_rst_acc", m.out_sum, 0);
      m.drain = 0; m.mode = 0; tick;
      // three-PE column drain
      col_mode = 1; tick;
      col_act0 = 10; col_act1 = 20; col_act2 = 30; col_vld = 1; tick;
      col_vld = 0; col_drain = 1; tick;
      chk("t4_row2", c2.out_sum, 30);
      chk("t4_row2_vld", c2.out_sum_vld, 1);
      col_drain = 0; tick;
      chk("t4_row1", c2.out_sum, 20);
      chk("t4_row1_vld", c2.out_sum_vld, 1);
      tick;
      chk("t4_row0", c2.out_sum, 10);
      chk("t4_row0_vld", c2.out_sum_vld, 1);
      tick;
      chk("t4_end_vld", c2.out_sum_vld, 0);
      // arithmetic corners
      s.load_en = 1; s.in_weight = 8'h80; s.in_weight_vld = 1;
      t.load_en = 1; t.in_weight = 8'd4; t.in_weight_vld = 1;
      w.load_en = 1; w.in_weight = 8'd4; w.in_weight_vld = 1; tick;
      s.load_en = 0; s.in_weight_vld = 0; s.swap = 1;
      t.load_en = 0; t.in_weight_vld = 0; t.swap = 1;
      w.load_en = 0; w.in_weight_vld = 0; w.swap = 1; tick;
      s.swap = 0; s.in_act = 8'h80; s.in_act_vld = 1; s.in_sum = 0; s.in_sum_vld = 1;
      t.swap = 0; t.in_act = 8'd8; t.in_act_vld = 1; t.in_sum = 16'hFFF0; t.in_sum_vld = 1;
      w.swap = 0; w.in_act = 8'd8; w.in_act_vld = 1; w.in_sum = 16'hFFF0; w.in_sum_vld = 1; tick;
      chk("t5_signed_minsq", s.out_sum, 32'h0_4000);
      chk("t5_sat_clamp", t.out_sum, 32'hFFFF);
      chk("t5_wrap", w.out_sum, 32'h0010);
      s.in_act = 8'd1; t.in_sum = 16'h0010; w.in_sum = 16'h0010; tick;
      chk("t5_signed_neg", s.out_sum, 32'hF_FF80);
      chk("t5_sat_no_ovf", t.out_sum, 32'h0030);
      chk("t5_wrap_no_ovf", w.out_sum, 32'h0030);
`ifdef PE_FAULT_INJ_EN
      m.in_act_vld = 0; m.in_sum = 20'h20; m.in_sum_vld = 1;
      fi_en = 1; fi_row = 0; fi_col = 0; fi_type = 2'd2; fi_mask = 20'h1; tick;
      chk("fi_flip", m.out_sum, 32'h21);
      chk("fi_vld", m.out_sum_vld, 1);
      chk("fi_nomatch_col", c0.out_sum, 0);
      fi_type = 2'd3; tick;
      chk("fi_none", m.out_sum, 32'h20);
      fi_type = 2'd1; fi_mask = 20'h3; tick;
      chk("fi_stuck1", m.out_sum, 32'h23);
      fi_type = 2'd0; fi_mask = 20'h20; tick;
      chk("fi_stuck0", m.out_sum, 32'h0);
      fi_en = 0; tick;
      chk("fi_off", m.out_sum, 32'h20);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
